// File: rtl/display_arb_pkg.sv
// Shared types and sizing helpers for the display bus arbiter.
// State and direction encodings are common to the top and any later users.
package display_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GUARD     = 3'd4,
        ST_HOST      = 3'd5
    } arb_state_e;

    typedef enum logic {
        DIR_TO_INTERNAL = 1'b0,
        DIR_TO_HOST     = 1'b1
    } arb_dir_e;

    function automatic int guard_cnt_width(input int handover_cycles);
        return $clog2(handover_cycles + 1);
    endfunction

    function automatic int timeout_cnt_width(input int start_timeout);
        return $clog2(start_timeout + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit double-flop synchronizer, asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b0;
            q        <= 1'b0;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/display_bus_arbiter.sv
// Owns the shared display SPI pins: schedules per-line transfers and hands the
// pins to the host only at line boundaries, with a CS-high guard on every swap.
module display_bus_arbiter
    import display_arb_pkg::*;
#(
    parameter int LINES_PER_FRAME = 4,
    parameter int LINE_IDX_WIDTH  = 2,
    parameter int HANDOVER_CYCLES = 4,
    parameter int START_TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      host_req,
    output logic                      host_gnt,
    output logic                      bus_sel,
    output logic                      disp_cs,
    input  logic                      line_ready,
    output logic                      line_ack,
    output logic                      xfer_start,
    input  logic                      xfer_running,
    output logic [LINE_IDX_WIDTH-1:0] line_index,
    output logic                      frame_done,
    output logic                      xfer_err
);

    localparam int GW = guard_cnt_width(HANDOVER_CYCLES);
    localparam int TW = timeout_cnt_width(START_TIMEOUT);
    localparam logic [GW-1:0] GUARD_LAST = GW'(HANDOVER_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(START_TIMEOUT - 1);
    localparam logic [LINE_IDX_WIDTH-1:0] LINE_LAST = LINE_IDX_WIDTH'(LINES_PER_FRAME - 1);

    logic          host_req_s;
    arb_state_e    state_reg;
    arb_dir_e      dir_reg;
    logic [GW-1:0] guard_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg;

    sync_2ff u_host_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (host_req),
        .q     (host_req_s)
    );

    // Pin-facing outputs are updated on the edge that enters the new state,
    // so they always reflect the state currently held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            dir_reg       <= DIR_TO_INTERNAL;
            guard_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            host_gnt      <= 1'b0;
            bus_sel       <= 1'b0;
            disp_cs       <= 1'b1;
            line_ack      <= 1'b0;
            xfer_start    <= 1'b0;
            frame_done    <= 1'b0;
            line_index    <= '0;
            xfer_err      <= 1'b0;
        end else begin
            xfer_start <= 1'b0;
            line_ack   <= 1'b0;
            frame_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (host_req_s) begin
                        state_reg     <= ST_GUARD;
                        dir_reg       <= DIR_TO_HOST;
                        guard_cnt_reg <= '0;
                        disp_cs       <= 1'b1;
                    end else begin
                        disp_cs <= 1'b0;
                        if (line_ready) begin
                            state_reg <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    xfer_start  <= 1'b1;
                    tmo_cnt_reg <= '0;
                    state_reg   <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (xfer_running) begin
                        state_reg <= ST_WAIT_DONE;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        xfer_err  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!xfer_running) begin
                        line_ack  <= 1'b1;
                        state_reg <= ST_IDLE;
                        if (line_index == LINE_LAST) begin
                            line_index <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            line_index <= line_index + LINE_IDX_WIDTH'(1);
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt_reg == GUARD_LAST) begin
                        if (dir_reg == DIR_TO_HOST) begin
                            state_reg <= ST_HOST;
                            bus_sel   <= 1'b1;
                            host_gnt  <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                            disp_cs   <= 1'b0;
                        end
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + GW'(1);
                    end
                end
                ST_HOST: begin
                    if (!host_req_s) begin
                        state_reg     <= ST_GUARD;
                        dir_reg       <= DIR_TO_INTERNAL;
                        guard_cnt_reg <= '0;
                        bus_sel       <= 1'b0;
                        host_gnt      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_bus_arbiter.sv
// Scoreboarded bench: expected line acks are queued by the stimulus thread and
// checked by an independent monitor; latencies are checked inline.
module tb_display_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       host_req;
    logic       host_gnt;
    logic       bus_sel;
    logic       disp_cs;
    logic       line_ready;
    logic       line_ack;
    logic       xfer_start;
    logic       xfer_running;
    logic [1:0] line_index;
    logic       frame_done;
    logic       xfer_err;

    typedef struct {
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_start = 0;
    int   cs_bad = 0;
    bit   cs_watch = 0;
    bit   spi_en = 1;
    int   busy = 0;

    display_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .host_req     (host_req),
        .host_gnt     (host_gnt),
        .bus_sel      (bus_sel),
        .disp_cs      (disp_cs),
        .line_ready   (line_ready),
        .line_ack     (line_ack),
        .xfer_start   (xfer_start),
        .xfer_running (xfer_running),
        .line_index   (line_index),
        .frame_done   (frame_done),
        .xfer_err     (xfer_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name, input int budget);
        n_vec++;
        n_err++;
        $display("FAIL %s: no event within %0d cycles", name, budget);
    endtask

    task automatic wait_start(input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            tick();
            edges++;
            if (xfer_start) return;
        end
        bound_expired("wait_xfer_start", budget);
        edges = -1;
    endtask

    task automatic wait_ack(input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            tick();
            edges++;
            if (line_ack) return;
        end
        bound_expired("wait_line_ack", budget);
        edges = -1;
    endtask

    task automatic wait_gnt(input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            tick();
            edges++;
            if (host_gnt) return;
        end
        bound_expired("wait_host_gnt", budget);
        edges = -1;
    endtask

    task automatic push_exp(input logic [1:0] idx, input logic fd);
        exp_t e;
        e.idx = idx;
        e.fd  = fd;
        exp_q.push_back(e);
    endtask

    // SPI controller model: busy for 10 cycles after each accepted start.
    initial begin
        xfer_running = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                busy = 0;
                xfer_running = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) xfer_running = 1'b0;
            end else if (xfer_start && spi_en) begin
                xfer_running = 1'b1;
                busy = 10;
            end
        end
    end

    // Monitor: pops one expectation per line_ack pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (cs_watch && disp_cs) cs_bad++;
            if (xfer_start) n_start++;
            if (frame_done && !line_ack) begin
                n_vec++;
                n_err++;
                $display("FAIL frame_done_alone: got 1, expected 0");
            end
            if (line_ack) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got ack at line_index %0d, expected none", line_index);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_line_index", line_index, e.idx);
                    check("ack_frame_done", frame_done, e.fd);
                    $display("ack: line_index=%0d frame_done=%0d", line_index, frame_done);
                end
            end
        end
    end

    initial begin
        int e;
        int starts_before;
        reset = 1'b1;
        host_req = 1'b0;
        line_ready = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_host_gnt", host_gnt, 0);
        check("rst_bus_sel", bus_sel, 0);
        check("rst_disp_cs", disp_cs, 1);
        check("rst_xfer_start", xfer_start, 0);
        check("rst_line_index", line_index, 0);
        check("rst_xfer_err", xfer_err, 0);
        reset = 1'b0;
        tick();
        check("idle_disp_cs", disp_cs, 0);

        // Full frame with line_ready held
        cs_watch = 1'b1;
        push_exp(2'd1, 1'b0);
        push_exp(2'd2, 1'b0);
        push_exp(2'd3, 1'b0);
        push_exp(2'd0, 1'b1);
        line_ready = 1'b1;
        for (int i = 0; i < 4; i++) wait_ack(40, e);
        line_ready = 1'b0;
        cs_watch = 1'b0;
        check("frame_cs_low", cs_bad, 0);
        check("frame_no_err", xfer_err, 0);
        tick();
        tick();

        // Host request from IDLE
        host_req = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("host_gnt_latency", host_gnt, (i == 7) ? 1 : 0);
            check("bus_sel_latency", bus_sel, (i == 7) ? 1 : 0);
            check("guard_disp_cs", disp_cs, (i >= 3) ? 1 : 0);
        end
        tick();
        tick();

        // Release; a pending line starts only after the guard
        push_exp(2'd1, 1'b0);
        push_exp(2'd2, 1'b0);
        host_req = 1'b0;
        line_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("release_bus_sel", bus_sel, (i < 3) ? 1 : 0);
        end
        wait_start(20, e);
        check("start_after_release", 3 + e, 9);
        wait_ack(40, e);
        wait_ack(40, e);

        // Host request mid-line at index 2, with line_ready still high
        wait_start(10, e);
        check("midline_index", line_index, 2);
        tick();
        tick();
        tick();
        host_req = 1'b1;
        push_exp(2'd3, 1'b0);
        wait_ack(40, e);
        check("gnt_held_off", host_gnt, 0);
        starts_before = n_start;
        wait_gnt(20, e);
        check("midline_gnt_latency", e, 5);
        check("simul_no_start", n_start, starts_before);
        tick();
        tick();

        // Release into a start timeout at index 3
        spi_en = 1'b0;
        host_req = 1'b0;
        wait_start(20, e);
        check("resume_latency", e, 9);
        check("resume_index", line_index, 3);
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 15) check("err_before_timeout", xfer_err, 0);
        end
        tick();
        check("err_at_timeout", xfer_err, 1);
        check("timeout_index", line_index, 3);
        spi_en = 1'b1;
        wait_start(5, e);
        check("retry_latency", e, 2);
        check("retry_index", line_index, 3);

        // Reset while in WAIT_DONE
        tick();
        tick();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("arst_host_gnt", host_gnt, 0);
        check("arst_bus_sel", bus_sel, 0);
        check("arst_disp_cs", disp_cs, 1);
        check("arst_line_ack", line_ack, 0);
        check("arst_xfer_start", xfer_start, 0);
        check("arst_frame_done", frame_done, 0);
        check("arst_line_index", line_index, 0);
        check("arst_xfer_err", xfer_err, 0);
        tick();
        tick();
        reset = 1'b0;
        line_ready = 1'b0;
        tick();
        tick();
        check("post_rst_disp_cs", disp_cs, 0);
        check("post_rst_xfer_err", xfer_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_bus_arbiter.md
# display_bus_arbiter

Owns the shared display SPI pins and sequences the per-line framebuffer transfers. It sits between the rasterizer's line-ready handshake, the `DisplayControllerSpi` start/running handshake, and the external host bypass request. Host requests are granted only at line boundaries, with a guard interval on every ownership change. The block replaces the free-running mux select and the constant `startTransfer` level with an explicit line/frame scheduler.

## Interface
Parameters:
- `LINES_PER_FRAME`, default 4. Number of line-buffer transfers per frame (Y_RESOLUTION / Y_LINE_RESOLUTION).
- `LINE_IDX_WIDTH`, default 2. Width of `line_index`; must satisfy 2^W ≥ LINES_PER_FRAME.
- `HANDOVER_CYCLES`, default 4. Guard cycles (≥1) with CS deasserted on each ownership change.
- `START_TIMEOUT`, default 16. Maximum cycles to wait for `xfer_running` to rise after `xfer_start`.

Ports:
- `clk`  in  1. Single clock for the block.
- `reset`  in  1. Asynchronous, active-high reset.
- `host_req`  in  1. Host bypass request; asynchronous pin, synchronized internally.
- `host_gnt`  out  1. Host owns the display pins.
- `bus_sel`  out  1. Pin mux select: 1 = host pins, 0 = internal controller.
- `disp_cs`  out  1. Internal chip select, active low.
- `line_ready`  in  1. Rasterizer has a complete line buffer (level).
- `line_ack`  out  1. One-cycle pulse: line transferred, buffer free.
- `xfer_start`  out  1. One-cycle start pulse to the SPI controller.
- `xfer_running`  in  1. SPI controller busy.
- `line_index`  out  LINE_IDX_WIDTH. Index of the next line to send.
- `frame_done`  out  1. One-cycle pulse with the `line_ack` of the last line.
- `xfer_err`  out  1. Sticky flag: start timeout occurred; cleared only by reset.

## Operation
- `host_req` passes through a 2-flop synchronizer (reset value 0). The output is `host_req_s`.
- The FSM has six states: IDLE, START, WAIT_BUSY, WAIT_DONE, GUARD, HOST.
- **IDLE**
  - If `host_req_s` is high: go to GUARD with direction = to-host.
  - Otherwise, if `line_ready` is high: go to START.
  - When both are high in the same cycle, host wins.
- **START**: assert `xfer_start` for one cycle, clear the timeout counter, go to WAIT_BUSY.
- **WAIT_BUSY**
  - When `xfer_running` is 1: go to WAIT_DONE.
  - If `START_TIMEOUT` cycles elapse first: set `xfer_err`, return to IDLE with no `line_ack` and no index change.
- **WAIT_DONE**
  - Waits for `xfer_running` to return to 0.
  - Then pulse `line_ack` and go to IDLE.
  - `line_index` increments, wrapping to 0 after LINES_PER_FRAME-1. On that wrap, `frame_done` pulses in the same cycle as `line_ack`.
- **GUARD**
  - Counts HANDOVER_CYCLES cycles with `bus_sel`=0, `disp_cs`=1 and `host_gnt`=0.
  - At the end, go to HOST if the direction is to-host, otherwise to IDLE.
- **HOST**
  - `bus_sel`=1 and `host_gnt`=1.
  - When `host_req_s` falls: go to GUARD with direction = to-internal.
- Host requests arriving during START/WAIT_* are held off until the current line completes. `line_index` is preserved across a host session, and internal transfers resume at the same line.
- `disp_cs`=0 in IDLE, START, WAIT_BUSY and WAIT_DONE; `disp_cs`=1 in GUARD and HOST.
- Reset mid-operation: all state returns to reset values immediately and any in-flight line is abandoned. `DisplayControllerSpi` shares the same reset.

## Timing
- Reset values:
  - `host_gnt`=0, `bus_sel`=0, `disp_cs`=1.
  - `line_ack`=0, `xfer_start`=0, `frame_done`=0.
  - `line_index`=0, `xfer_err`=0.
  - FSM state = IDLE.
- All outputs are registered.
- `line_ready` → `xfer_start`: 2 clock edges (IDLE→START, then the pulse is visible).
- `host_req` rise → `host_gnt` rise: 3 + HANDOVER_CYCLES edges when the FSM is in IDLE (7 at default).
- `host_req` fall → `bus_sel` fall: 3 edges. IDLE is re-entered HANDOVER_CYCLES edges later.
- `line_ready` is sampled only in IDLE. The rasterizer must drop it or present a new line after seeing `line_ack`.
- `xfer_running` high in the same cycle as `xfer_start` is accepted.

## Structure
- Package `display_arb_pkg`:
  - State enum (6 states, 3 bits).
  - Direction bit encoding.
  - Guard counter width function `$clog2(HANDOVER_CYCLES+1)`.
  - Timeout counter width `$clog2(START_TIMEOUT+1)`.
- One sub-module, `sync_2ff`: a 1-bit double-flop synchronizer with asynchronous active-high reset to 0. It is reused later for `serial_cs`.

## Test plan
- **Frame sequence:** hold `line_ready`=1 with a model that runs `xfer_running` for 10 cycles after each start → 4 `line_ack` pulses; `line_index` goes 1,2,3,0; a single `frame_done` with the 4th ack; `disp_cs`=0 throughout.
- **Host request in IDLE:** assert `host_req` in IDLE → `bus_sel`=`host_gnt`=1 exactly 7 edges later; `disp_cs`=1 during the 4 guard cycles. Release → `bus_sel`=0 after 3 edges; the next `xfer_start` no earlier than 4 edges after that.
- **Host request mid-line:** assert `host_req` during WAIT_DONE at `line_index`=2 → `host_gnt` only after `line_ack`. After release, the next transfer is at `line_index`=3.
- **Simultaneous requests:** `host_req_s` and `line_ready` both high in IDLE → GUARD entered; no `xfer_start` issued.
- **Start timeout:** `xfer_running` never rises → `xfer_err`=1 after 16 cycles in WAIT_BUSY; no `line_ack`; `line_index` unchanged; retries on the next IDLE.
- **Reset mid-transfer:** reset during WAIT_DONE at `line_index`=3 → all outputs at reset values in the same cycle (asynchronous); `xfer_err` cleared.
